// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the memory stage: status codes, load/store opcodes,
// access width codes and FSM state encoding.
package mem_access_unit_pkg;

    // Execute-stage status codes
    localparam logic [2:0] ST_NONE   = 3'b000;
    localparam logic [2:0] ST_REG    = 3'b001;
    localparam logic [2:0] ST_STORE  = 3'b010;
    localparam logic [2:0] ST_LOAD   = 3'b011;
    localparam logic [2:0] ST_BRANCH = 3'b100;
    localparam logic [2:0] ST_JAL    = 3'b101;

    // Memory opcodes
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    // Width codes hold the index of the last byte (N-1), which is what the
    // byte counter is compared against.
    localparam logic [1:0] W_BYTE = 2'd0;
    localparam logic [1:0] W_HALF = 2'd1;
    localparam logic [1:0] W_WORD = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_LAST   = 2'd2
    } state_e;

    // Unknown opcodes under a memory status fall back to a full word.
    function automatic logic [1:0] width_code(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: width_code = W_BYTE;
            OP_LH, OP_LHU, OP_SH: width_code = W_HALF;
            default:              width_code = W_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Sign/zero extension of assembled load lanes according to the load opcode.
module load_extend
    import mem_access_unit_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [31:0] raw,
    output logic [31:0] word
);

    // Select extension by opcode; words and unknown ops pass through raw
    always_comb begin
        case (op)
            OP_LB:   word = {{24{raw[7]}}, raw[7:0]};
            OP_LBU:  word = {24'd0, raw[7:0]};
            OP_LH:   word = {{16{raw[15]}}, raw[15:0]};
            OP_LHU:  word = {16'd0, raw[15:0]};
            default: word = raw;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: byte-serial loads/stores over the RAM port with a pipeline
// stall, and one-cycle forwarding of register-writing results to writeback.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [2:0]        status_in,
    input  logic [5:0]        op_in,
    input  logic [ADDR_W-1:0] mem_address_in,
    input  logic [31:0]       target_data_in,
    input  logic [4:0]        reg_address_in,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic              stall_req,
    output logic              wb_en,
    output logic [4:0]        wb_reg_address,
    output logic [31:0]       wb_data
);

    state_e            state;
    logic [1:0]        k;
    logic [1:0]        last_q;
    logic              is_load_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0][7:0]   data_q;
    logic [3:0][7:0]   lanes;
    logic [5:0]        op_q;
    logic [4:0]        rd_q;
    logic [3:0][7:0]   raw;
    logic [31:0]       ext_word;
    logic              mem_req;
    logic              reg_req;

    assign mem_req   = in_valid && (status_in == ST_STORE || status_in == ST_LOAD);
    assign reg_req   = in_valid && (status_in == ST_REG || status_in == ST_JAL);
    assign stall_req = (state != S_IDLE) || mem_req;

    // RAM port is driven only during ACCESS; ram_wr falls with async reset
    always_comb begin
        ram_wr   = 1'b0;
        ram_addr = '0;
        ram_dout = '0;
        if (state == S_ACCESS) begin
            ram_addr = addr_q + ADDR_W'(k);
            if (!is_load_q) begin
                ram_wr   = 1'b1;
                ram_dout = data_q[k];
            end
        end
    end

    // Final byte arrives in LAST straight from ram_din, merged over the lanes
    always_comb begin
        raw         = lanes;
        raw[last_q] = ram_din;
    end

    load_extend u_ext (
        .op   (op_q),
        .raw  (raw),
        .word (ext_word)
    );

    // Access FSM, byte counter, lane capture and registered writeback
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            k              <= '0;
            last_q         <= '0;
            is_load_q      <= 1'b0;
            addr_q         <= '0;
            data_q         <= '0;
            lanes          <= '0;
            op_q           <= '0;
            rd_q           <= '0;
            wb_en          <= 1'b0;
            wb_reg_address <= '0;
            wb_data        <= '0;
        end else begin
            wb_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mem_req) begin
                        addr_q    <= mem_address_in;
                        data_q    <= target_data_in;
                        op_q      <= op_in;
                        rd_q      <= reg_address_in;
                        last_q    <= width_code(op_in);
                        is_load_q <= (status_in == ST_LOAD);
                        k         <= '0;
                        lanes     <= '0;
                        state     <= S_ACCESS;
                    end else if (reg_req) begin
                        wb_en          <= (reg_address_in != 5'd0);
                        wb_reg_address <= reg_address_in;
                        wb_data        <= target_data_in;
                    end
                end
                S_ACCESS: begin
                    // ram_din now holds the byte addressed in the previous cycle
                    if (is_load_q && k != 2'd0)
                        lanes[k - 2'd1] <= ram_din;
                    if (k == last_q) begin
                        k     <= '0;
                        state <= is_load_q ? S_LAST : S_IDLE;
                    end else begin
                        k <= k + 2'd1;
                    end
                end
                S_LAST: begin
                    wb_data        <= ext_word;
                    wb_en          <= (rd_q != 5'd0);
                    wb_reg_address <= rd_q;
                    state          <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: table of directed transactions, reset abort
// sequence, and randomized transactions against a transaction-level model.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [2:0]  status_in;
    logic [5:0]  op_in;
    logic [31:0] mem_address_in;
    logic [31:0] target_data_in;
    logic [4:0]  reg_address_in;
    logic [7:0]  ram_din = 8'h00;
    logic [7:0]  ram_dout;
    logic [31:0] ram_addr;
    logic        ram_wr;
    logic        stall_req;
    logic        wb_en;
    logic [4:0]  wb_reg_address;
    logic [31:0] wb_data;

    int errors = 0;
    int checks = 0;

    logic [7:0] ram     [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .status_in(status_in),
        .op_in(op_in), .mem_address_in(mem_address_in),
        .target_data_in(target_data_in), .reg_address_in(reg_address_in),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_addr(ram_addr),
        .ram_wr(ram_wr), .stall_req(stall_req), .wb_en(wb_en),
        .wb_reg_address(wb_reg_address), .wb_data(wb_data)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    // Byte RAM: read data appears the cycle after the address
    always @(posedge clk) begin
        if (ram_wr) ram[ram_addr] = ram_dout;
        ram_din <= ram_rd(ram_addr);
    end

    task automatic poke(input logic [31:0] a, input logic [7:0] b);
        ram[a] = b;
        ref_mem[a] = b;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 1;
            OP_LH, OP_LHU, OP_SH: return 2;
            default:              return 4;
        endcase
    endfunction

    // Little-endian gather of N bytes, then arithmetic sign fix-up
    function automatic logic [31:0] model_load(input logic [5:0] op, input logic [31:0] a);
        logic [31:0] w = 32'd0;
        int n = nbytes(op);
        for (int i = 0; i < n; i++) w = w + (32'(ref_rd(a + 32'(i))) << (8 * i));
        if (op == OP_LB && w >= 32'd128)   w = w - 32'd256;
        if (op == OP_LH && w >= 32'd32768) w = w - 32'd65536;
        return w;
    endfunction

    // One transaction: bundle valid in cycle 0 only, 8 observed cycles
    task automatic run_txn(input logic v, input logic [2:0] st, input logic [5:0] op,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic [4:0] rd,
                           output logic got_en, output logic [31:0] got_data);
        bit is_ld = v && st == 3'b011;
        bit is_st = v && st == 3'b010;
        bit is_rw = v && (st == 3'b001 || st == 3'b101);
        int n = nbytes(op);
        logic [31:0] exp_ld = model_load(op, addr);
        bit io, e_stall, e_wb;
        logic [31:0] e_addr;
        logic [7:0]  e_dout;
        got_en = 1'b0;
        got_data = 32'd0;
        @(posedge clk); #1;
        in_valid = v; status_in = st; op_in = op;
        mem_address_in = addr; target_data_in = data; reg_address_in = rd;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            io      = (is_ld || is_st) && c >= 1 && c <= n;
            e_stall = (is_ld && c <= n + 1) || (is_st && c <= n);
            e_addr  = io ? addr + 32'(c - 1) : 32'd0;
            e_dout  = (is_st && io) ? data[8*(c-1) +: 8] : 8'h00;
            e_wb    = rd != 5'd0 && ((is_ld && c == n + 2) || (is_rw && c == 1));
            chk($sformatf("c%0d stall_req", c), 64'(stall_req), 64'(e_stall));
            chk($sformatf("c%0d ram wr/addr/dout", c), 64'({ram_wr, ram_addr, ram_dout}),
                64'({is_st && io, e_addr, e_dout}));
            chk($sformatf("c%0d wb_en", c), 64'(wb_en), 64'(e_wb));
            if (e_wb)
                chk($sformatf("c%0d wb reg/data", c), 64'({wb_reg_address, wb_data}),
                    64'({rd, is_ld ? exp_ld : data}));
            if (wb_en && !got_en) begin
                got_en = 1'b1;
                got_data = wb_data;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        if (is_st)
            for (int i = 0; i < n; i++) ref_mem[addr + 32'(i)] = data[8*i +: 8];
    endtask

    typedef struct {
        logic [2:0]  st;
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        exp_en;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic        g_en;
        logic [31:0] g_data;
        logic [2:0]  st;
        logic [5:0]  op;
        logic [31:0] addr, data, e_data;
        logic [4:0]  rd;
        logic        v, e_en;
        logic [5:0]  ld_ops[6];
        logic [5:0]  st_ops[3];

        rst = 1'b0; in_valid = 1'b0; status_in = 3'b000; op_in = 6'h0;
        mem_address_in = 32'h0; target_data_in = 32'h0; reg_address_in = 5'h0;

        // Directed vectors with hand-computed results
        tbl[0]  = '{3'b011, OP_LW,  32'h100,      32'h0,        5'd3,  1'b1, 32'h12345678};
        tbl[1]  = '{3'b011, OP_LB,  32'h40,       32'h0,        5'd4,  1'b1, 32'hFFFFFF80};
        tbl[2]  = '{3'b011, OP_LBU, 32'h40,       32'h0,        5'd4,  1'b1, 32'h00000080};
        tbl[3]  = '{3'b011, OP_LH,  32'h50,       32'h0,        5'd6,  1'b1, 32'hFFFFFFFE};
        tbl[4]  = '{3'b011, OP_LHU, 32'h50,       32'h0,        5'd7,  1'b1, 32'h0000FFFE};
        tbl[5]  = '{3'b010, OP_SH,  32'h200,      32'hDEADBEEF, 5'd8,  1'b0, 32'h0};
        tbl[6]  = '{3'b001, OP_LW,  32'h0,        32'h7,        5'd5,  1'b1, 32'h7};
        tbl[7]  = '{3'b001, OP_LW,  32'h0,        32'h9,        5'd0,  1'b0, 32'h0};
        tbl[8]  = '{3'b100, OP_LW,  32'h0,        32'h7,        5'd5,  1'b0, 32'h0};
        tbl[9]  = '{3'b101, OP_LW,  32'h0,        32'h1234,     5'd31, 1'b1, 32'h1234};
        tbl[10] = '{3'b011, OP_LW,  32'hFFFFFFFE, 32'h0,        5'd2,  1'b1, 32'h44332211};
        tbl[11] = '{3'b011, OP_LW,  32'h0,        32'h0,        5'd0,  1'b0, 32'h0};

        poke(32'h100, 8'h78); poke(32'h101, 8'h56); poke(32'h102, 8'h34); poke(32'h103, 8'h12);
        poke(32'h40, 8'h80);  poke(32'h50, 8'hFE);  poke(32'h51, 8'hFF);
        poke(32'h202, 8'h5A);
        poke(32'hFFFFFFFE, 8'h11); poke(32'hFFFFFFFF, 8'h22);
        poke(32'h0, 8'h33); poke(32'h1, 8'h44);
        poke(32'h301, 8'h11); poke(32'h302, 8'h22); poke(32'h303, 8'h33);

        // Reset state
        #12;
        chk("reset outputs", 64'({stall_req, ram_wr, ram_addr, ram_dout}), 64'd0);
        chk("reset wb", 64'({wb_en, wb_reg_address, wb_data}), 64'd0);
        @(negedge clk); rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_txn(1'b1, tbl[i].st, tbl[i].op, tbl[i].addr, tbl[i].data, tbl[i].rd, g_en, g_data);
            chk($sformatf("tbl%0d wb_en", i), 64'(g_en), 64'(tbl[i].exp_en));
            if (tbl[i].exp_en) chk($sformatf("tbl%0d wb_data", i), 64'(g_data), 64'(tbl[i].exp_data));
        end
        chk("SH bytes 0x200/0x201/0x202",
            64'({ram_rd(32'h200), ram_rd(32'h201), ram_rd(32'h202)}), 64'(24'hEFBE5A));

        // SW aborted by reset in cycle 2: only byte 0 reached RAM
        @(posedge clk); #1;
        in_valid = 1'b1; status_in = 3'b010; op_in = OP_SW;
        mem_address_in = 32'h300; target_data_in = 32'hCAFEF00D; reg_address_in = 5'd1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("SW mid-access ram_wr", 64'(ram_wr), 64'd1);
        rst = 1'b0; #1;
        chk("async abort outputs", 64'({stall_req, ram_wr, ram_addr, ram_dout}), 64'd0);
        chk("async abort wb", 64'({wb_en, wb_reg_address, wb_data}), 64'd0);
        ref_mem[32'h300] = 8'h0D;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        chk("post-reset idle", 64'({stall_req, ram_wr}), 64'd0);
        run_txn(1'b1, 3'b011, OP_LW, 32'h300, 32'h0, 5'd9, g_en, g_data);
        chk("post-reset LW", 64'({g_en, g_data}), 64'({1'b1, 32'h3322110D}));

        // Randomized transactions against the model
        ld_ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, 6'h3F};
        st_ops = '{OP_SB, OP_SH, OP_SW};
        for (int i = 0; i < 64; i++) poke(32'h1000 + 32'(i), 8'($urandom));
        for (int i = 0; i < 4; i++)  poke(32'hFFFFFFFC + 32'(i), 8'($urandom));
        for (int r = 0; r < 50; r++) begin
            v = ($urandom_range(0, 7) != 0);
            case ($urandom_range(0, 5))
                0: st = 3'b000; 1: st = 3'b001; 2: st = 3'b010;
                3: st = 3'b011; 4: st = 3'b100; default: st = 3'b101;
            endcase
            if (st == 3'b011)      op = ld_ops[$urandom_range(0, 5)];
            else if (st == 3'b010) op = st_ops[$urandom_range(0, 2)];
            else                   op = 6'($urandom);
            addr = (r % 8 == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                : 32'h1000 + 32'($urandom_range(0, 60));
            data = $urandom;
            rd   = 5'($urandom);
            e_en   = v && rd != 5'd0 && (st == 3'b011 || st == 3'b001 || st == 3'b101);
            e_data = (st == 3'b011) ? model_load(op, addr) : data;
            run_txn(v, st, op, addr, data, rd, g_en, g_data);
            chk($sformatf("rnd%0d wb_en", r), 64'(g_en), 64'(e_en));
            if (e_en) chk($sformatf("rnd%0d wb_data", r), 64'(g_data), 64'(e_data));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory stage that sits downstream of the execute stage and consumes its status/op/address/data bundle.
- Performs loads (status 011) and stores (status 010) over the byte-serial RAM port, one byte per cycle, and holds the pipeline with stall_req while doing so.
- Assembles and sign- or zero-extends load data.
- Forwards register-writing results (status 001, 101) to writeback with one cycle of latency.

Parameters:
ADDR_W, 32, width of the RAM byte address and of mem_address_in

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  execute bundle valid this cycle
status_in  in  3  001 reg write, 010 store, 011 load, 100 branch, 101 jal/jalr, 000 none
op_in  in  6  opcode from the shared op constants (LB..SW)
mem_address_in  in  ADDR_W  effective address
target_data_in  in  32  store data or ALU/link result
reg_address_in  in  5  destination register
ram_din  in  8  read byte; valid the cycle after its address was issued
ram_dout  out  8  write byte
ram_addr  out  ADDR_W  byte address
ram_wr  out  1  1 = write, 0 = read
stall_req  out  1  hold upstream stages
wb_en  out  1  writeback strobe, one cycle
wb_reg_address  out  5  writeback register
wb_data  out  32  writeback value

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. All outputs, counters and latched fields are 0.
- Width from op: LB/LBU/SB give N=1; LH/LHU/SH give N=2; LW/SW give N=4. Any other op with a memory status is treated as N=4.
- States: IDLE, ACCESS, LAST.
- stall_req = (state != IDLE) OR (state == IDLE AND in_valid AND status_in ∈ {010, 011}). It is combinational, so it is raised in the accept cycle.
- IDLE with a memory op:
  - Latch address, data, op, rd and N; clear byte counter k.
  - Next state ACCESS.
  - wb_en=0 next cycle.
- IDLE with status 001 or 101:
  - Next cycle: wb_en = (reg_address_in != 0), wb_reg_address = rd, wb_data = target_data_in.
- IDLE with status 100, 000, or in_valid=0: next cycle wb_en=0.
- ACCESS, one byte per cycle, k = 0..N-1:
  - ram_addr = addr + k, modulo 2^ADDR_W (wrap-around is legal; no alignment check).
  - Store: ram_wr=1, ram_dout = data[8k+7:8k].
  - Load: ram_wr=0, and the byte captured this cycle (k ≥ 1) from ram_din goes into lane k-1.
  - After k = N-1: a store goes to IDLE; a load goes to LAST.
- LAST (load only):
  - ram_wr=0, ram_addr=0.
  - Capture ram_din into lane N-1.
  - Register wb_data: sign-extended for LB/LH, zero-extended for LBU/LHU, raw for LW.
  - Register wb_en = (rd != 0) and wb_reg_address = rd.
  - Next state IDLE.
- Timing with the accept cycle = cycle 0:
  - Load: bytes are issued in cycles 1..N; the result is visible with wb_en=1 in cycle N+2; stall_req is high in cycles 0..N+1.
  - Store: bytes are written in cycles 1..N; stall_req is high in cycles 0..N; no writeback.
- While not IDLE, in_valid and the input bundle are ignored. Upstream holds the bundle stable under stall; the unit does not re-sample it.
- Outside ACCESS: ram_wr=0, ram_addr=0, ram_dout=0. wb_en is a single-cycle pulse.
- Reset asserted mid-access: the access is aborted immediately and ram_wr drops asynchronously. A partial store is not rolled back.

Decomposition:
- Shared package/defines: status codes (001/010/011/100/101), op constants LB..SW, and width codes.
- One sub-module, load_extend: combinational; inputs op and 32-bit raw lanes, output the sign- or zero-extended word.
- The FSM, counter and lane registers stay in mem_access_unit.

Test Plan:
- LW at 0x100, RAM bytes 78,56,34,12 → ram_addr 0x100..0x103 in cycles 1..4 with ram_wr=0; wb_data=0x12345678 and wb_en=1 in cycle 6; stall_req high in cycles 0..5.
- LB at 0x40 holding 0x80 → wb_data=0xFFFFFF80 in cycle 3. The same access as LBU → 0x00000080. LH at bytes 0xFE,0xFF → 0xFFFFFFFE.
- SH with data 0xDEADBEEF at 0x200 → cycle 1 writes 0xEF to 0x200, cycle 2 writes 0xBE to 0x201; stall_req high in cycles 0..2; wb_en never asserts; 0x202 is untouched.
- Status 001 with rd=5 and data 7 → wb_en=1, wb_reg_address=5, wb_data=7 next cycle, stall_req=0 throughout. With rd=0 → wb_en=0. Status 100 → wb_en=0.
- LW at 0xFFFFFFFE → ram_addr sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- SW started, rst pulled low in cycle 2 → all outputs 0 immediately. After release: state IDLE, stall_req=0, and a new LW completes normally.
